// File: rtl/bvult_bvmul_skolem_checker.sv
// Checks a candidate Skolem witness x for the bvult/bvmul invertibility
// problem: computes (x*s) mod 2^W with a bit-serial shift-add multiplier,
// then reports whether x*s <u t holds, or whether no witness is needed (t=0).
module bvult_bvmul_skolem_checker #(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     s,
    input  logic [W-1:0]     t,
    input  logic [W-1:0]     x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     prod,
    output logic             sat,
    output logic             ic,
    output logic             pass,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] fail_cnt
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0]    IDX_LAST = IW'(W - 1);
    localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, MUL, CMP, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  s_r, t_r, x_r, acc;
    logic [IW-1:0] idx;
    logic          last_bit;
    logic          cmp_sat, cmp_ic, cmp_pass;

    assign last_bit = (idx == IDX_LAST);
    // Verdict terms evaluated on the finished product while in CMP.
    assign cmp_sat  = (acc < t_r);
    assign cmp_ic   = (t_r != '0);
    assign cmp_pass = ~cmp_ic | cmp_sat;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; only IDLE accepts new work.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MUL;
            end
            MUL:  if (last_bit) state_nxt = CMP;
            CMP:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, shift-add accumulation (carries past bit W-1 dropped),
    // and the verdict/counter registers which are only written in CMP so they
    // stay frozen through a stalled DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_r       <= '0;
            t_r       <= '0;
            x_r       <= '0;
            acc       <= '0;
            idx       <= '0;
            prod      <= '0;
            sat       <= 1'b0;
            ic        <= 1'b0;
            pass      <= 1'b0;
            check_cnt <= '0;
            fail_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    s_r <= s;
                    t_r <= t;
                    x_r <= x;
                    acc <= '0;
                    idx <= '0;
                end
                MUL: begin
                    if (x_r[idx]) acc <= acc + (s_r << idx);
                    idx <= idx + IDX_ONE;
                end
                CMP: begin
                    prod <= acc;
                    sat  <= cmp_sat;
                    ic   <= cmp_ic;
                    pass <= cmp_pass;
                    if (check_cnt != CNT_MAX) check_cnt <= check_cnt + CNT_ONE;
                    if (!cmp_pass && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
                end
                default: ;
            endcase
        end
    end
endmodule
